lstm_wbuf: RTL and testbench
============================

LSTM_WBUF -- requirements
Module: lstm_wbuf

Interface
REQ-001 SHALL have parameter D_WL, default 24, meaning the fixed-point word length of one unit weight.
REQ-002 SHALL have parameter UNITS_NUM, default 5, meaning the number of unit weights packed in one row.
REQ-003 SHALL have parameter DEPTH, default 156, meaning the number of rows per gate.
REQ-004 SHALL have parameter GATES, default 4, meaning the number of gate banks: 0=i, 1=f, 2=g, 3=o.
REQ-005 SHALL derive AW=clog2(DEPTH), GW=clog2(GATES) and RW=UNITS_NUM*D_WL as local constants.
REQ-006 SHALL have the port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have the ports ld_valid (in, 1), ld_ready (out, 1), ld_gate (in, GW), ld_addr (in, AW) and ld_data (in, RW): the row load port.
REQ-009 SHALL have the ports rd_start (in, 1), rd_gate (in, GW), rd_base (in, AW) and rd_len (in, AW+1): the burst read request.
REQ-010 SHALL have the port rd_busy, output, 1 bit: high while a burst is in progress.
REQ-011 SHALL have the ports w_valid (out, 1), w_ready (in, 1), w_data (out, RW) and w_last (out, 1): the weight stream; unit 0 occupies the MSBs.
REQ-012 SHALL have the port err, output, 1 bit: a sticky flag for an illegal request.

Function
REQ-013 SHALL store GATES*DEPTH rows of RW bits in a synchronous-read array.
REQ-014 SHALL use the FSM states IDLE, READ and DRAIN.
REQ-015 SHALL drive ld_ready=1 only in IDLE; a load occurs on ld_valid&&ld_ready and writes ld_data to row [ld_gate][ld_addr].
REQ-016 SHALL ignore a load with ld_addr>=DEPTH or ld_gate>=GATES, set err and accept the beat.
REQ-017 SHALL treat rd_start in IDLE with 1<=rd_len and rd_base+rd_len<=DEPTH as legal: latch gate/base/len and go IDLE->READ; rd_busy=1 from the next cycle.
REQ-018 SHALL treat rd_start in IDLE with rd_len==0, an out-of-range span or rd_gate>=GATES as illegal: set err and stay in IDLE.
REQ-019 SHALL ignore rd_start while rd_busy=1, with no err.
REQ-020 SHALL, when ld_valid and rd_start occur in the same IDLE cycle, perform both; a burst covering that row returns the new data.
REQ-021 SHALL in READ issue one array read per cycle, advancing the address by 1 from rd_base, whenever the 2-entry output skid buffer has space counting in-flight reads.
REQ-022 SHALL move READ->DRAIN after issuing rd_len reads, and DRAIN->IDLE on the handshake of the w_last beat; rd_busy=0 in the cycle after that handshake.
REQ-023 SHALL assert the first w_valid 2 cycles after the accepted rd_start, and sustain 1 row/cycle while w_ready=1.
REQ-024 SHALL hold w_data and w_last stable while w_valid&&!w_ready; no row is lost or duplicated under any w_ready pattern.
REQ-025 SHALL assert w_last with the row at rd_base+rd_len-1 only.
REQ-026 SHALL keep err set until rst.

Reset
REQ-027 SHALL on rst force state=IDLE, rd_busy=0, w_valid=0, w_last=0, w_data=0, ld_ready=0 (1 from the next cycle) and err=0, and empty the skid buffer.
REQ-028 SHALL retain array contents across rst; a reset mid-burst aborts the burst with no further w_valid.

Structure
REQ-029 SHALL place the gate index encoding and the FSM state enum in the shared package lstm_pkg.
REQ-030 SHALL implement the skid buffer as sub-module wbuf_skid (2-entry, RW wide, valid/ready both sides).

Verification
REQ-031 Load rows 0..4 of gate 3 with 'h000001..'h000005 in unit 0, then rd_start gate 3, base 0, len 5, w_ready=1 -> 5 beats on consecutive cycles, first beat 2 cycles after the request, w_last on the 5th beat, rd_busy low afterwards.
REQ-032 Same burst with w_ready toggling 1,0,0,1,... -> all 5 rows in order, data stable during stalls, no duplicates.
REQ-033 rd_start with base 150, len 7 (DEPTH 156) -> err=1, no w_valid, state IDLE; rd_start with len 0 -> err=1.
REQ-034 Same-cycle load of row 10 gate 1 ('hABCDEF in unit 0) and rd_start gate 1, base 10, len 1 -> one beat carrying 'hABCDEF with w_last=1.
REQ-035 rst asserted on the 3rd beat of a len-8 burst -> w_valid=0 next cycle, rd_busy=0, err=0; a re-issued burst returns the preloaded data unchanged.
REQ-036 rd_start during a busy burst -> ignored, err stays 0, the current burst completes normally.

Source files
------------

// File: rtl/lstm_pkg.sv
// lstm_pkg: gate bank encoding and burst FSM states shared by the LSTM weight buffer
package lstm_pkg;
   typedef enum logic [1:0] {GATE_I = 2'd0, GATE_F = 2'd1, GATE_G = 2'd2, GATE_O = 2'd3} gate_e;
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;
endpackage

// File: rtl/wbuf_skid.sv
// wbuf_skid: 2-entry skid FIFO; the head entry drives the output directly from a register
module wbuf_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);
   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] s0_q, s0_d, s1_q, s1_d;
   logic         push, pop;
   assign in_ready_o  = cnt_q != 2'd2;
   assign out_valid_o = cnt_q != 2'd0;
   assign out_data_o  = s0_q;
   always_comb begin
      push  = in_valid_i && in_ready_o;
      pop   = out_valid_o && out_ready_i;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      s0_d  = !pop ? ((push && cnt_q == 2'd0) ? in_data_i : s0_q)
                   : (cnt_q == 2'd2) ? s1_q : push ? in_data_i : s0_q;
      s1_d  = (push && !pop && cnt_q == 2'd1) ? in_data_i : s1_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         s0_q  <= '0;
         s1_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         s0_q  <= s0_d;
         s1_q  <= s1_d;
      end
   end
endmodule

// File: rtl/lstm_wbuf.sv
// lstm_wbuf: per-gate LSTM weight row store with a row load port and a credit-paced burst read stream
module lstm_wbuf import lstm_pkg::*; #(
   parameter  int D_WL      = 24,
   parameter  int UNITS_NUM = 5,
   parameter  int DEPTH     = 156,
   parameter  int GATES     = 4,
   localparam int AW        = $clog2(DEPTH),
   localparam int GW        = $clog2(GATES),
   localparam int RW        = UNITS_NUM * D_WL
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [GW-1:0] ld_gate,
   input  logic [AW-1:0] ld_addr,
   input  logic [RW-1:0] ld_data,
   input  logic          rd_start,
   input  logic [GW-1:0] rd_gate,
   input  logic [AW-1:0] rd_base,
   input  logic [AW:0]   rd_len,
   output logic          rd_busy,
   output logic          w_valid,
   input  logic          w_ready,
   output logic [RW-1:0] w_data,
   output logic          w_last,
   output logic          err
);
   localparam int IW = $clog2(GATES * DEPTH);
   state_e        state_q, state_d;
   logic [GW-1:0] gate_q, gate_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   left_q, left_d;
   logic          rvalid_q, rlast_q, err_q, err_d;
   logic [RW-1:0] rdata_q;
   logic [RW-1:0] mem_q [GATES*DEPTH];
   logic          ld_fire, ld_ok, rd_ok, rd_go, issue, skid_ready;
   logic [RW:0]   skid_out;
   function automatic logic [IW-1:0] row_idx(input logic [GW-1:0] g, input logic [AW-1:0] a);
      return IW'(int'(g) * DEPTH + int'(a));
   endfunction
   assign ld_ready = state_q == IDLE && !rst;
   assign ld_fire  = ld_valid && ld_ready;
   assign ld_ok    = int'(ld_gate) < GATES && int'(ld_addr) < DEPTH;
   assign rd_ok    = rd_len != '0 && int'(rd_gate) < GATES && int'(rd_base) + int'(rd_len) <= DEPTH;
   assign rd_go    = state_q == IDLE && rd_start;
   assign rd_busy  = state_q != IDLE;
   assign err      = err_q;
   // Issue only if the row will find a skid slot: skid plus in-flight read, less this cycle's pop, stays under 2.
   assign issue    = state_q == READ && (!w_valid || w_ready || (skid_ready && !rvalid_q));
   always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      addr_d  = addr_q;
      left_d  = left_q;
      err_d   = err_q || (ld_fire && !ld_ok) || (rd_go && !rd_ok);
      if (rd_go && rd_ok) begin
         state_d = READ;
         gate_d  = rd_gate;
         addr_d  = rd_base;
         left_d  = rd_len;
      end
      if (issue) begin
         addr_d  = addr_q + AW'(1);
         left_d  = left_q - (AW+1)'(1);
         state_d = left_q == (AW+1)'(1) ? DRAIN : READ;
      end
      if (state_q == DRAIN && w_valid && w_ready && w_last) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gate_q   <= '0;
         addr_q   <= '0;
         left_q   <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gate_q   <= gate_d;
         addr_q   <= addr_d;
         left_q   <= left_d;
         rvalid_q <= issue;
         rlast_q  <= issue && left_q == (AW+1)'(1);
         err_q    <= err_d;
      end
   end
   // The row array has no reset so weights survive rst.
   always_ff @(posedge clk) begin
      if (ld_fire && ld_ok) mem_q[row_idx(ld_gate, ld_addr)] <= ld_data;
      if (issue) rdata_q <= mem_q[row_idx(gate_q, addr_q)];
   end
   wbuf_skid #(.W(RW + 1)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (rvalid_q),
      .in_ready_o (skid_ready),
      .in_data_i  ({rlast_q, rdata_q}),
      .out_valid_o(w_valid),
      .out_ready_i(w_ready),
      .out_data_o (skid_out)
   );
   assign {w_last, w_data} = skid_out;
endmodule

// File: tb/tb_lstm_wbuf.sv
// tb_lstm_wbuf: randomized bench checking lstm_wbuf bursts against a row-array reference model
module tb_lstm_wbuf;
   import lstm_pkg::*;
   localparam int D_WL = 24, UNITS_NUM = 5, DEPTH = 156, GATES = 4;
   localparam int AW = $clog2(DEPTH), GW = $clog2(GATES), RW = UNITS_NUM * D_WL;
   logic          clk = 1'b0, rst;
   logic          ld_valid, ld_ready, rd_start, rd_busy, w_valid, w_ready, w_last, err;
   logic [GW-1:0] ld_gate, rd_gate;
   logic [AW-1:0] ld_addr, rd_base;
   logic [AW:0]   rd_len;
   logic [RW-1:0] ld_data, w_data;
   int            passed = 0, total = 0;
   logic [RW-1:0] model [GATES][DEPTH];
   logic [RW-1:0] got_data[$];
   logic          got_last[$];
   int            got_cyc[$];
   int            first_k, stall_bad;
   bit            timeout, busy0;
   always #5 clk = ~clk;
   lstm_wbuf dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_gate(ld_gate), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_start(rd_start), .rd_gate(rd_gate), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last), .err(err)
   );
   function automatic logic [RW-1:0] unit0(input logic [D_WL-1:0] v);
      return {v, {(RW-D_WL){1'b0}}};
   endfunction
   function automatic logic [RW-1:0] rnd_row();
      return RW'({$urandom, $urandom, $urandom, $urandom});
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask
   task automatic load_row(input int g, input int a, input logic [RW-1:0] d);
      ld_valid = 1'b1;
      ld_gate  = GW'(g);
      ld_addr  = AW'(a);
      ld_data  = d;
      step();
      ld_valid = 1'b0;
      if (g < GATES && a < DEPTH) model[g][a] = d;
   endtask
   // Issues a burst and records every accepted beat; mode 0 ready=1, mode 1 ready 1,0,0,..., mode 2 random.
   task automatic run_burst(input int g, input int base, input int len, input int mode, input bit inject);
      bit          stalled = 1'b0, done = 1'b0;
      logic [RW:0] held = '0;
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
      first_k   = -1;
      stall_bad = 0;
      rd_start  = 1'b1;
      rd_gate   = GW'(g);
      rd_base   = AW'(base);
      rd_len    = (AW+1)'(len);
      step();
      rd_start = 1'b0;
      ld_valid = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         if (k == 0) busy0 = rd_busy;
         if (stalled && (!w_valid || {w_last, w_data} !== held)) stall_bad++;
         if (w_valid && first_k < 0) first_k = k;
         w_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 2) : 1'($urandom_range(0, 1));
         if (inject && k == 3) begin
            rd_start = 1'b1;
            rd_gate  = '0;
            rd_base  = '0;
            rd_len   = (AW+1)'(3);
         end
         if (w_valid && w_ready) begin
            got_data.push_back(w_data);
            got_last.push_back(w_last);
            got_cyc.push_back(k);
            done = w_last;
         end
         stalled = w_valid && !w_ready;
         held    = {w_last, w_data};
         step();
         rd_start = 1'b0;
      end
      timeout = !done;
      w_ready = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++;
      if ({w_valid, w_last, rd_busy, err, ld_ready} !== 5'b0) $display("FAIL reset_flags got v/l/busy/err/ldr=%b want 00000", {w_valid, w_last, rd_busy, err, ld_ready});
      else passed++;
      total++;
      if (w_data !== '0) $display("FAIL reset_wdata got %h want 0", w_data);
      else passed++;
      rst = 1'b0;
      step();
      total++;
      if (ld_ready !== 1'b1) $display("FAIL reset_ldready got %b want 1", ld_ready);
      else passed++;
   endtask
   task automatic test_burst();
      for (int i = 0; i < 5; i++) load_row(GATE_O, i, unit0(D_WL'(i + 1)));
      run_burst(GATE_O, 0, 5, 0, 1'b0);
      total++;
      if (timeout || got_data.size() != 5) $display("FAIL burst_count got %0d beats timeout=%0d want 5", got_data.size(), timeout);
      else passed++;
      total++;
      if (first_k != 2) $display("FAIL burst_latency got %0d want 2", first_k);
      else passed++;
      total++;
      if (busy0 !== 1'b1) $display("FAIL burst_busy got %b want 1", busy0);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (i >= got_data.size() || got_data[i] !== unit0(D_WL'(i + 1)) || got_last[i] !== (i == 4) || got_cyc[i] != 2 + i)
            $display("FAIL burst_beat%0d got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                     i, got_data[i], got_last[i], got_cyc[i], unit0(D_WL'(i + 1)), i == 4, 2 + i);
         else passed++;
      end
      total++;
      if (rd_busy !== 1'b0 || w_valid !== 1'b0) $display("FAIL burst_after got busy=%b valid=%b want 0 0", rd_busy, w_valid);
      else passed++;
   endtask
   task automatic test_stall();
      for (int m = 1; m <= 2; m++) begin
         run_burst(GATE_O, 0, 5, m, 1'b0);
         total++;
         if (timeout || got_data.size() != 5) $display("FAIL stall%0d_count got %0d want 5", m, got_data.size());
         else passed++;
         total++;
         if (stall_bad != 0) $display("FAIL stall%0d_hold got %0d unstable cycles want 0", m, stall_bad);
         else passed++;
         for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= got_data.size() || got_data[i] !== model[3][i] || got_last[i] !== (i == 4))
               $display("FAIL stall%0d_beat%0d got %h/%b want %h/%b", m, i, got_data[i], got_last[i], model[3][i], i == 4);
            else passed++;
         end
      end
   endtask
   task automatic test_same_cycle();
      load_row(GATE_F, 10, rnd_row());
      ld_valid = 1'b1;
      ld_gate  = GATE_F;
      ld_addr  = AW'(10);
      ld_data  = unit0(24'hABCDEF);
      model[1][10] = unit0(24'hABCDEF);
      run_burst(GATE_F, 10, 1, 0, 1'b0);
      total++;
      if (timeout || got_data.size() != 1) $display("FAIL same_count got %0d want 1", got_data.size());
      else passed++;
      total++;
      if (got_data.size() < 1 || got_data[0] !== unit0(24'hABCDEF) || got_last[0] !== 1'b1)
         $display("FAIL same_beat got %h/%b want %h/1", got_data[0], got_last[0], unit0(24'hABCDEF));
      else passed++;
   endtask
   task automatic test_busy_ignore();
      bit seen = 1'b0;
      for (int i = 20; i < 26; i++) load_row(GATE_G, i, rnd_row());
      run_burst(GATE_G, 20, 6, 0, 1'b1);
      total++;
      if (timeout || got_data.size() != 6) $display("FAIL busy_count got %0d want 6", got_data.size());
      else passed++;
      for (int i = 0; i < 6; i++) begin
         total++;
         if (i >= got_data.size() || got_data[i] !== model[2][20 + i] || got_last[i] !== (i == 5))
            $display("FAIL busy_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], model[2][20 + i], i == 5);
         else passed++;
      end
      for (int k = 0; k < 4; k++) begin
         if (w_valid || rd_busy) seen = 1'b1;
         step();
      end
      total++;
      if (seen || err !== 1'b0) $display("FAIL busy_ignored got extra_activity=%0d err=%b want 0 0", seen, err);
      else passed++;
   endtask
   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         int g    = $urandom_range(0, GATES - 1);
         int len  = $urandom_range(1, 12);
         int base = $urandom_range(0, DEPTH - len);
         for (int i = 0; i < len; i++) if ($urandom_range(0, 3) != 0 || n == 0) load_row(g, base + i, rnd_row());
         for (int i = 0; i < len; i++) if (model[g][base + i] === 'x) load_row(g, base + i, rnd_row());
         run_burst(g, base, len, 2, 1'b0);
         total++;
         if (timeout || got_data.size() != len || stall_bad != 0)
            $display("FAIL rand%0d_count got %0d beats stall_bad=%0d want %0d 0", n, got_data.size(), stall_bad, len);
         else passed++;
         for (int i = 0; i < len; i++) begin
            total++;
            if (i >= got_data.size() || got_data[i] !== model[g][base + i] || got_last[i] !== (i == len - 1))
               $display("FAIL rand%0d_beat%0d got %h/%b want %h/%b", n, i, got_data[i], got_last[i], model[g][base + i], i == len - 1);
            else passed++;
         end
      end
   endtask
   task automatic test_illegal();
      bit seen = 1'b0;
      rd_start = 1'b1;
      rd_gate  = '0;
      rd_base  = AW'(150);
      rd_len   = (AW+1)'(7);
      step();
      rd_start = 1'b0;
      total++;
      if (err !== 1'b1 || rd_busy !== 1'b0) $display("FAIL ill_span got err=%b busy=%b want 1 0", err, rd_busy);
      else passed++;
      for (int k = 0; k < 5; k++) begin
         if (w_valid || rd_busy) seen = 1'b1;
         step();
      end
      total++;
      if (seen || ld_ready !== 1'b1) $display("FAIL ill_span_idle got activity=%0d ld_ready=%b want 0 1", seen, ld_ready);
      else passed++;
      do_reset();
      rd_start = 1'b1;
      rd_base  = '0;
      rd_len   = '0;
      step();
      rd_start = 1'b0;
      total++;
      if (err !== 1'b1 || rd_busy !== 1'b0) $display("FAIL ill_len0 got err=%b busy=%b want 1 0", err, rd_busy);
      else passed++;
      do_reset();
      load_row(GATE_F, 44, rnd_row());
      load_row(GATE_I, 200, rnd_row());
      total++;
      if (err !== 1'b1) $display("FAIL ill_load_err got %b want 1", err);
      else passed++;
      run_burst(GATE_F, 44, 1, 0, 1'b0);
      total++;
      if (got_data.size() != 1 || got_data[0] !== model[1][44]) $display("FAIL ill_load_alias got %h want %h", got_data[0], model[1][44]);
      else passed++;
   endtask
   task automatic test_rst_mid();
      int beats = 0;
      for (int i = 30; i < 38; i++) load_row(GATE_I, i, rnd_row());
      w_ready  = 1'b1;
      rd_start = 1'b1;
      rd_gate  = '0;
      rd_base  = AW'(30);
      rd_len   = (AW+1)'(8);
      step();
      rd_start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (w_valid) beats++;
         if (beats == 3) break;
         step();
      end
      total++;
      if (beats != 3 || w_data !== model[0][32]) $display("FAIL rst_beat3 got beats=%0d data=%h want 3 %h", beats, w_data, model[0][32]);
      else passed++;
      rst = 1'b1;
      step();
      total++;
      if (w_valid !== 1'b0 || rd_busy !== 1'b0 || err !== 1'b0) $display("FAIL rst_abort got v=%b busy=%b err=%b want 0 0 0", w_valid, rd_busy, err);
      else passed++;
      rst = 1'b0;
      w_ready = 1'b0;
      step();
      total++;
      if (w_valid !== 1'b0 || rd_busy !== 1'b0) $display("FAIL rst_quiet got v=%b busy=%b want 0 0", w_valid, rd_busy);
      else passed++;
      run_burst(GATE_I, 30, 8, 2, 1'b0);
      total++;
      if (timeout || got_data.size() != 8) $display("FAIL rst_reissue_count got %0d want 8", got_data.size());
      else passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (i >= got_data.size() || got_data[i] !== model[0][30 + i] || got_last[i] !== (i == 7))
            $display("FAIL rst_reissue_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], model[0][30 + i], i == 7);
         else passed++;
      end
   endtask
   initial begin
      rst      = 1'b1;
      ld_valid = 1'b0;
      ld_gate  = '0;
      ld_addr  = '0;
      ld_data  = '0;
      rd_start = 1'b0;
      rd_gate  = '0;
      rd_base  = '0;
      rd_len   = '0;
      w_ready  = 1'b0;
      test_reset();
      test_burst();
      test_stall();
      test_same_cycle();
      test_busy_ignore();
      test_random();
      test_illegal();
      test_rst_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
